// File: rtl/clock_scale_pkg.sv
// Shared definitions for the divided-clock scale detector.
package clock_scale_pkg;

    localparam int SCALE_W = 11;
    localparam int CNT_W   = 12;
    localparam int MATCH_W = 4;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = 12'd2048;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_LOCKED
    } cs_det_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizer chain for an asynchronous level plus a both-polarity edge
// detector on the synchronized value. The chain is deliberately not reset so
// that a reset never fabricates an edge from a stale flop value.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic sig_i,
    output logic edge_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;

    // Shift the raw input through the synchronizer, then keep one extra copy.
    always_ff @(posedge clk_i) begin
        chain_q <= {chain_q[STAGES-2:0], sig_i};
        prev_q  <= chain_q[STAGES-1];
    end

    assign edge_o = chain_q[STAGES-1] ^ prev_q;

endmodule

// File: rtl/clock_scale_detect.sv
// Recovers the scale factor of a divided clock by timing the interval
// between successive edges, publishing each measurement and declaring lock
// once enough consecutive measurements agree.
module clock_scale_detect
    import clock_scale_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sig_in,
    output logic [SCALE_W-1:0] scale_factor,
    output logic               meas_stb,
    output logic               locked,
    output logic               timeout
);

    logic               sigEdge;
    cs_det_state_t      state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [MATCH_W-1:0] matchCnt_q;
    logic [MATCH_W-1:0] matchCnt_d;
    logic [SCALE_W-1:0] scaleFactor_q;
    logic [SCALE_W-1:0] measVal_d;
    logic               measStb_q;
    logic               locked_q;
    logic               timeout_q;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk),
        .sig_i  (sig_in),
        .edge_o (sigEdge)
    );

    // Interval counter next value, the measurement it represents, and the
    // run length of identical measurements if this edge is accepted. The
    // 11-bit subtraction maps a saturated count of 2048 onto 2047.
    always_comb begin
        measVal_d = cnt_q[SCALE_W-1:0] - SCALE_W'(1);

        matchCnt_d = MATCH_W'(1);
        if (measVal_d == scaleFactor_q) begin
            matchCnt_d = matchCnt_q + MATCH_W'(1);
        end

        cnt_d = cnt_q + CNT_W'(1);
        if (sigEdge) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == TIMEOUT_CNT) begin
            cnt_d = cnt_q;
        end
    end

    // Measurement state machine with registered outputs; reset and disable
    // both discard any partial interval, and an edge always beats a timeout.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            matchCnt_q    <= '0;
            scaleFactor_q <= '0;
            measStb_q     <= 1'b0;
            locked_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            measStb_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= cnt_d;
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_ARM;
                end
                ST_ARM: begin
                    if (sigEdge) begin
                        state_q <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (sigEdge) begin
                        scaleFactor_q <= measVal_d;
                        measStb_q     <= 1'b1;
                        matchCnt_q    <= matchCnt_d;
                        if (matchCnt_d == MATCH_W'(LOCK_COUNT)) begin
                            locked_q <= 1'b1;
                            state_q  <= ST_LOCKED;
                        end
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        timeout_q  <= 1'b1;
                        locked_q   <= 1'b0;
                        matchCnt_q <= '0;
                        state_q    <= ST_ARM;
                    end
                end
                ST_LOCKED: begin
                    if (sigEdge) begin
                        measStb_q <= 1'b1;
                        if (measVal_d != scaleFactor_q) begin
                            scaleFactor_q <= measVal_d;
                            locked_q      <= 1'b0;
                            matchCnt_q    <= MATCH_W'(1);
                            state_q       <= ST_MEASURE;
                        end
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        timeout_q  <= 1'b1;
                        locked_q   <= 1'b0;
                        matchCnt_q <= '0;
                        state_q    <= ST_ARM;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign scale_factor = scaleFactor_q;
    assign meas_stb     = measStb_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_clock_scale_detect.sv
// Bench for clock_scale_detect: drives sig_in as a divided clock with chosen
// half-periods and compares every strobe against expectations derived from
// the half-period list.
module tb_clock_scale_detect;

    localparam int SYNC = 2;
    localparam int LOCK = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sig_in;
    logic [10:0] scale_factor;
    logic        meas_stb;
    logic        locked;
    logic        timeout;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    int stbVal[$];
    bit stbLock[$];
    int stbCyc[$];
    int toCount = 0;
    int toCyc   = 0;

    int expVal[$];
    bit expLock[$];

    clock_scale_detect #(
        .SYNC_STAGES (SYNC),
        .LOCK_COUNT  (LOCK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sig_in       (sig_in),
        .scale_factor (scale_factor),
        .meas_stb     (meas_stb),
        .locked       (locked),
        .timeout      (timeout)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    // Free-running cycle index used to time strobes and timeouts.
    always @(posedge clk) cyc++;

    // Record every strobe and timeout pulse away from the active edge.
    always @(negedge clk) begin
        if (meas_stb) begin
            stbVal.push_back(int'(scale_factor));
            stbLock.push_back(locked);
            stbCyc.push_back(cyc);
        end
        if (timeout) begin
            toCount++;
            toCyc = cyc;
        end
    end

    // Expected strobes: each interval of hp cycles reads hp-1, and lock holds
    // whenever the current run of identical readings is LOCK or longer.
    task automatic modelSequence(input int hp[$]);
        int run;
        int prev;
        int v;
        expVal.delete();
        expLock.delete();
        run  = 0;
        prev = -1;
        foreach (hp[i]) begin
            v    = hp[i] - 1;
            run  = (run > 0 && v == prev) ? run + 1 : 1;
            prev = v;
            expVal.push_back(v);
            expLock.push_back(run >= LOCK);
        end
    endtask

    // Optionally re-arm via enable, then toggle sig_in once and again after
    // each listed half-period.
    task automatic applyStimulus(input int hp[$], input bit restart);
        if (restart) begin
            en = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            en = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        stbVal.delete();
        stbLock.delete();
        stbCyc.delete();
        toCount = 0;
        sig_in = ~sig_in;
        foreach (hp[i]) begin
            repeat (hp[i]) @(posedge clk);
            #1;
            sig_in = ~sig_in;
        end
        repeat (SYNC + 4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        en     = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (scale_factor !== 11'd0) $display("[TB] FAIL reset scale_factor: got %0d expected 0", scale_factor); else passes++;
        checks++; if (meas_stb !== 1'b0) $display("[TB] FAIL reset meas_stb: got %b expected 0", meas_stb); else passes++;
        checks++; if (locked !== 1'b0) $display("[TB] FAIL reset locked: got %b expected 0", locked); else passes++;
        checks++; if (timeout !== 1'b0) $display("[TB] FAIL reset timeout: got %b expected 0", timeout); else passes++;
        rst = 1'b0;
    endtask

    task automatic test_loopback_s5();
        int hp[$];
        repeat (6) hp.push_back(6);
        applyStimulus(hp, 1'b1);
        modelSequence(hp);
        checks++; if (stbVal.size() !== expVal.size()) $display("[TB] FAIL s5 strobe count: got %0d expected %0d", stbVal.size(), expVal.size()); else passes++;
        for (int i = 0; i < expVal.size() && i < stbVal.size(); i++) begin
            checks++; if (stbVal[i] !== expVal[i]) $display("[TB] FAIL s5 value[%0d]: got %0d expected %0d", i, stbVal[i], expVal[i]); else passes++;
            checks++; if (stbLock[i] !== expLock[i]) $display("[TB] FAIL s5 locked[%0d]: got %b expected %b", i, stbLock[i], expLock[i]); else passes++;
        end
        checks++; if (toCount !== 0) $display("[TB] FAIL s5 timeouts: got %0d expected 0", toCount); else passes++;
    endtask

    task automatic test_boundaries_timeout();
        int hp[$];
        int lastStb;
        hp = '{1, 1, 1, 1, 2048, 2048, 2048};
        applyStimulus(hp, 1'b1);
        modelSequence(hp);
        checks++; if (stbVal.size() !== expVal.size()) $display("[TB] FAIL bound strobe count: got %0d expected %0d", stbVal.size(), expVal.size()); else passes++;
        for (int i = 0; i < expVal.size() && i < stbVal.size(); i++) begin
            checks++; if (stbVal[i] !== expVal[i]) $display("[TB] FAIL bound value[%0d]: got %0d expected %0d", i, stbVal[i], expVal[i]); else passes++;
            checks++; if (stbLock[i] !== expLock[i]) $display("[TB] FAIL bound locked[%0d]: got %b expected %b", i, stbLock[i], expLock[i]); else passes++;
        end
        checks++; if (toCount !== 0) $display("[TB] FAIL bound early timeout: got %0d expected 0", toCount); else passes++;
        lastStb = (stbCyc.size() > 0) ? stbCyc[stbCyc.size()-1] : 0;
        repeat (2200) @(posedge clk);
        #1;
        checks++; if (toCount !== 1) $display("[TB] FAIL timeout count: got %0d expected 1", toCount); else passes++;
        checks++; if (toCyc - lastStb !== 2048) $display("[TB] FAIL timeout delay: got %0d expected 2048", toCyc - lastStb); else passes++;
        checks++; if (locked !== 1'b0) $display("[TB] FAIL timeout locked: got %b expected 0", locked); else passes++;
        checks++; if (scale_factor !== 11'd2047) $display("[TB] FAIL timeout held scale: got %0d expected 2047", scale_factor); else passes++;
    endtask

    task automatic test_scale_change();
        int hp[$];
        hp = '{11, 11, 11, 11, 21, 21, 21, 21};
        applyStimulus(hp, 1'b1);
        modelSequence(hp);
        checks++; if (stbVal.size() !== expVal.size()) $display("[TB] FAIL change strobe count: got %0d expected %0d", stbVal.size(), expVal.size()); else passes++;
        for (int i = 0; i < expVal.size() && i < stbVal.size(); i++) begin
            checks++; if (stbVal[i] !== expVal[i]) $display("[TB] FAIL change value[%0d]: got %0d expected %0d", i, stbVal[i], expVal[i]); else passes++;
            checks++; if (stbLock[i] !== expLock[i]) $display("[TB] FAIL change locked[%0d]: got %b expected %b", i, stbLock[i], expLock[i]); else passes++;
        end
    endtask

    task automatic test_reset_mid();
        int hp[$];
        hp = '{101, 101, 101, 101};
        applyStimulus(hp, 1'b1);
        checks++; if (locked !== 1'b1) $display("[TB] FAIL rstmid pre locked: got %b expected 1", locked); else passes++;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (scale_factor !== 11'd0) $display("[TB] FAIL rstmid scale_factor: got %0d expected 0", scale_factor); else passes++;
        checks++; if (locked !== 1'b0) $display("[TB] FAIL rstmid locked: got %b expected 0", locked); else passes++;
        checks++; if (meas_stb !== 1'b0) $display("[TB] FAIL rstmid meas_stb: got %b expected 0", meas_stb); else passes++;
        checks++; if (timeout !== 1'b0) $display("[TB] FAIL rstmid timeout: got %b expected 0", timeout); else passes++;
        hp = '{101, 101, 101};
        applyStimulus(hp, 1'b0);
        modelSequence(hp);
        checks++; if (stbVal.size() !== expVal.size()) $display("[TB] FAIL rstmid strobe count: got %0d expected %0d", stbVal.size(), expVal.size()); else passes++;
        for (int i = 0; i < expVal.size() && i < stbVal.size(); i++) begin
            checks++; if (stbVal[i] !== expVal[i]) $display("[TB] FAIL rstmid value[%0d]: got %0d expected %0d", i, stbVal[i], expVal[i]); else passes++;
            checks++; if (stbLock[i] !== expLock[i]) $display("[TB] FAIL rstmid locked[%0d]: got %b expected %b", i, stbLock[i], expLock[i]); else passes++;
        end
    endtask

    task automatic test_enable_drop();
        int hp[$];
        hp = '{11, 11, 11, 11};
        applyStimulus(hp, 1'b1);
        checks++; if (locked !== 1'b1) $display("[TB] FAIL endrop pre locked: got %b expected 1", locked); else passes++;
        en = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (locked !== 1'b0) $display("[TB] FAIL endrop locked: got %b expected 0", locked); else passes++;
        checks++; if (scale_factor !== 11'd0) $display("[TB] FAIL endrop scale_factor: got %0d expected 0", scale_factor); else passes++;
        repeat (2) @(posedge clk);
        #1;
        en = 1'b1;
        applyStimulus(hp, 1'b0);
        modelSequence(hp);
        checks++; if (stbVal.size() !== expVal.size()) $display("[TB] FAIL endrop strobe count: got %0d expected %0d", stbVal.size(), expVal.size()); else passes++;
        for (int i = 0; i < expVal.size() && i < stbVal.size(); i++) begin
            checks++; if (stbVal[i] !== expVal[i]) $display("[TB] FAIL endrop value[%0d]: got %0d expected %0d", i, stbVal[i], expVal[i]); else passes++;
            checks++; if (stbLock[i] !== expLock[i]) $display("[TB] FAIL endrop locked[%0d]: got %b expected %b", i, stbLock[i], expLock[i]); else passes++;
        end
    endtask

    task automatic test_alternate();
        int hp[$];
        for (int i = 0; i < 8; i++) hp.push_back((i % 2 == 0) ? 7 : 8);
        applyStimulus(hp, 1'b1);
        modelSequence(hp);
        checks++; if (stbVal.size() !== expVal.size()) $display("[TB] FAIL alt strobe count: got %0d expected %0d", stbVal.size(), expVal.size()); else passes++;
        for (int i = 0; i < expVal.size() && i < stbVal.size(); i++) begin
            checks++; if (stbVal[i] !== expVal[i]) $display("[TB] FAIL alt value[%0d]: got %0d expected %0d", i, stbVal[i], expVal[i]); else passes++;
            checks++; if (stbLock[i] !== expLock[i]) $display("[TB] FAIL alt locked[%0d]: got %b expected %b", i, stbLock[i], expLock[i]); else passes++;
        end
    endtask

    task automatic test_random();
        int hp[$];
        int v;
        int reps;
        for (int round = 0; round < 4; round++) begin
            hp.delete();
            for (int seg = 0; seg < 3; seg++) begin
                v    = int'($urandom_range(1, 30));
                reps = int'($urandom_range(1, 5));
                repeat (reps) hp.push_back(v);
            end
            applyStimulus(hp, 1'b1);
            modelSequence(hp);
            checks++; if (stbVal.size() !== expVal.size()) $display("[TB] FAIL rand%0d strobe count: got %0d expected %0d", round, stbVal.size(), expVal.size()); else passes++;
            for (int i = 0; i < expVal.size() && i < stbVal.size(); i++) begin
                checks++; if (stbVal[i] !== expVal[i]) $display("[TB] FAIL rand%0d value[%0d]: got %0d expected %0d", round, i, stbVal[i], expVal[i]); else passes++;
                checks++; if (stbLock[i] !== expLock[i]) $display("[TB] FAIL rand%0d locked[%0d]: got %b expected %b", round, i, stbLock[i], expLock[i]); else passes++;
            end
            checks++; if (toCount !== 0) $display("[TB] FAIL rand%0d timeouts: got %0d expected 0", round, toCount); else passes++;
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        $display("[TB] clock_scale_detect bench start");
        test_reset();
        test_loopback_s5();
        test_boundaries_timeout();
        test_scale_change();
        test_reset_mid();
        test_enable_drop();
        test_alternate();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
